// File: rtl/alu_result_stage_if.sv
// Handshake bundle between execute, the ALU result stage and the memory stage.
// The master side is the execute/memory environment; the slave side is the stage itself.
interface alu_result_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_class;
    logic [DATA_W-1:0] in_result;
    logic              in_ne;
    logic              in_lt;
    logic              in_ovf;
    logic [REG_W-1:0]  in_rd;
    logic [DATA_W-1:0] in_target;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [REG_W-1:0]  out_rd;
    logic              out_we;
    logic              out_is_mem;
    logic              br_taken;
    logic [DATA_W-1:0] br_target;

    modport master (
        output in_valid, in_class, in_result, in_ne, in_lt, in_ovf, in_rd, in_target,
        output flush, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_we, out_is_mem,
        input  br_taken, br_target
    );

    modport slave (
        input  in_valid, in_class, in_result, in_ne, in_lt, in_ovf, in_rd, in_target,
        input  flush, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_we, out_is_mem,
        output br_taken, br_target
    );
endinterface

// File: rtl/alu_result_stage.sv
// Execute-to-memory register with 2-entry skid buffer, branch resolution and flush.
// Optional macro ALU_OVF_STATUS_EN remaps ADD/SUB/ADDI overflow into a status write to EXC_REG.
module alu_result_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int EXC_REG = 30
) (
    input logic             clock,
    input logic             reset,
    alu_result_stage_if.slave bus
);

`ifdef ALU_OVF_STATUS_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    localparam logic [2:0] C_NOP  = 3'd0;
    localparam logic [2:0] C_ADD  = 3'd1;
    localparam logic [2:0] C_SUB  = 3'd2;
    localparam logic [2:0] C_ADDI = 3'd3;
    localparam logic [2:0] C_BNE  = 3'd5;
    localparam logic [2:0] C_BLT  = 3'd6;
    localparam logic [2:0] C_MEM  = 3'd7;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_W-1:0]  rd;
        logic              we;
        logic              is_mem;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    function automatic logic [DATA_W-1:0] status_code(input logic [2:0] cls);
        logic [DATA_W-1:0] code;
        code = '0;
        case (cls)
            C_ADD:   code = DATA_W'(1);
            C_SUB:   code = DATA_W'(3);
            C_ADDI:  code = DATA_W'(2);
            default: code = '0;
        endcase
        return code;
    endfunction

    function automatic entry_t form_entry(input logic [2:0]        cls,
                                          input logic [DATA_W-1:0] res,
                                          input logic [REG_W-1:0]  rd,
                                          input logic              ovf);
        entry_t e;
        e.result = res;
        e.rd     = rd;
        e.we     = (cls != C_MEM);
        e.is_mem = (cls == C_MEM);
        if (OVF_EN && ovf && (cls == C_ADD || cls == C_SUB || cls == C_ADDI)) begin
            e.result = status_code(cls);
            e.rd     = REG_W'(EXC_REG);
            e.we     = 1'b1;
        end
        // Register 0 is hardwired; checked after any remap so the final rd decides.
        if (e.rd == '0) e.we = 1'b0;
        return e;
    endfunction

    state_t            state_q;
    entry_t            head_q;
    entry_t            skid_q;
    logic              in_ready_q;
    logic              br_taken_q;
    logic [DATA_W-1:0] br_target_q;

    logic   accept;
    logic   is_branch;
    logic   enq;
    logic   deq;
    logic   taken;
    entry_t new_e;

    always_comb begin
        accept    = bus.in_valid & in_ready_q & ~bus.flush;
        is_branch = (bus.in_class == C_BNE) || (bus.in_class == C_BLT);
        enq       = accept && !is_branch && (bus.in_class != C_NOP);
        deq       = (state_q != EMPTY) && bus.out_ready;
        taken     = accept && (((bus.in_class == C_BNE) && bus.in_ne) ||
                               ((bus.in_class == C_BLT) && bus.in_lt));
        new_e     = form_entry(bus.in_class, bus.in_result, bus.in_rd, bus.in_ovf);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            br_taken_q  <= taken;
            br_target_q <= taken ? bus.in_target : '0;
            if (bus.flush) begin
                state_q    <= EMPTY;
                in_ready_q <= 1'b1;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (enq) begin
                            head_q  <= new_e;
                            state_q <= ONE;
                        end
                    end
                    ONE: begin
                        if (enq && deq) begin
                            head_q <= new_e;
                        end else if (enq) begin
                            skid_q     <= new_e;
                            state_q    <= FULL;
                            in_ready_q <= 1'b0;
                        end else if (deq) begin
                            state_q <= EMPTY;
                        end
                    end
                    FULL: begin
                        // No accept is possible here, so only a retire moves the skid entry up.
                        if (deq) begin
                            head_q     <= skid_q;
                            state_q    <= ONE;
                            in_ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q    <= EMPTY;
                        in_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = (state_q != EMPTY);
    assign bus.out_result = head_q.result;
    assign bus.out_rd     = head_q.rd;
    assign bus.out_we     = head_q.we;
    assign bus.out_is_mem = head_q.is_mem;
    assign bus.br_taken   = br_taken_q;
    assign bus.br_target  = br_target_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  alu_result_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

  alu_result_stage #(.DATA_W(32), .REG_W(5), .EXC_REG(30)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] cls, input logic [31:0] res, input logic [4:0] rd,
                       input logic ne, input logic lt, input logic ovf, input logic [31:0] tgt);
    bus.in_valid  = 1'b1;
    bus.in_class  = cls;
    bus.in_result = res;
    bus.in_rd     = rd;
    bus.in_ne     = ne;
    bus.in_lt     = lt;
    bus.in_ovf    = ovf;
    bus.in_target = tgt;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_class = 3'd0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    idle();
    bus.in_result = '0;
    bus.in_rd     = '0;
    bus.in_ne     = 1'b0;
    bus.in_lt     = 1'b0;
    bus.in_ovf    = 1'b0;
    bus.in_target = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $error("FAIL rst_out_valid observed=%0h expected=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $error("FAIL rst_in_ready observed=%0h expected=1", bus.in_ready); end
    checks++; if (bus.br_taken !== 1'b0) begin failures++; $error("FAIL rst_br_taken observed=%0h expected=0", bus.br_taken); end
    checks++; if (bus.out_result !== 32'h0) begin failures++; $error("FAIL rst_out_result observed=%0h expected=0", bus.out_result); end
    reset = 1'b1;
    tick();

    // Single ADD with downstream ready
    drive(3'd1, 32'h0000_0007, 5'd5, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $error("FAIL add_valid observed=%0h expected=1", bus.out_valid); end
    checks++; if (bus.out_result !== 32'h7) begin failures++; $error("FAIL add_result observed=%0h expected=7", bus.out_result); end
    checks++; if (bus.out_rd !== 5'd5) begin failures++; $error("FAIL add_rd observed=%0h expected=5", bus.out_rd); end
    checks++; if (bus.out_we !== 1'b1) begin failures++; $error("FAIL add_we observed=%0h expected=1", bus.out_we); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $error("FAIL add_retired observed=%0h expected=0", bus.out_valid); end

    // Backpressure: three ADDs with out_ready low
    bus.out_ready = 1'b0;
    drive(3'd1, 32'd1, 5'd1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $error("FAIL bp_ready_after1 observed=%0h expected=1", bus.in_ready); end
    drive(3'd1, 32'd2, 5'd2, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $error("FAIL bp_ready_after2 observed=%0h expected=0", bus.in_ready); end
    drive(3'd1, 32'd3, 5'd3, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $error("FAIL bp_still_full observed=%0h expected=0", bus.in_ready); end
    checks++; if (bus.out_result !== 32'd1) begin failures++; $error("FAIL bp_head1 observed=%0h expected=1", bus.out_result); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_result !== 32'd2) begin failures++; $error("FAIL bp_head2 observed=%0h expected=2", bus.out_result); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $error("FAIL bp_ready_again observed=%0h expected=1", bus.in_ready); end
    tick();
    idle();
    checks++; if (bus.out_result !== 32'd3) begin failures++; $error("FAIL bp_head3 observed=%0h expected=3", bus.out_result); end
    checks++; if (bus.out_rd !== 5'd3) begin failures++; $error("FAIL bp_head3_rd observed=%0h expected=3", bus.out_rd); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $error("FAIL bp_drained observed=%0h expected=0", bus.out_valid); end

    // Branches
    drive(3'd5, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0040);
    tick();
    idle();
    checks++; if (bus.br_taken !== 1'b1) begin failures++; $error("FAIL bne_taken observed=%0h expected=1", bus.br_taken); end
    checks++; if (bus.br_target !== 32'h40) begin failures++; $error("FAIL bne_target observed=%0h expected=40", bus.br_target); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $error("FAIL bne_no_entry observed=%0h expected=0", bus.out_valid); end
    tick();
    checks++; if (bus.br_taken !== 1'b0) begin failures++; $error("FAIL bne_pulse_end observed=%0h expected=0", bus.br_taken); end
    drive(3'd6, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0080);
    tick();
    idle();
    checks++; if (bus.br_taken !== 1'b0) begin failures++; $error("FAIL blt_not_taken observed=%0h expected=0", bus.br_taken); end
    drive(3'd6, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0124);
    bus.out_ready = 1'b0;
    tick();
    idle();
    checks++; if (bus.br_taken !== 1'b1) begin failures++; $error("FAIL blt_taken observed=%0h expected=1", bus.br_taken); end
    checks++; if (bus.br_target !== 32'h124) begin failures++; $error("FAIL blt_target observed=%0h expected=124", bus.br_target); end
    bus.out_ready = 1'b1;

    // NOP is not enqueued; rd=0 suppresses write; MEM entry
    drive(3'd0, 32'h55, 5'd7, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $error("FAIL nop_no_entry observed=%0h expected=0", bus.out_valid); end
    drive(3'd4, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.out_result !== 32'hDEAD_BEEF) begin failures++; $error("FAIL rd0_result observed=%0h expected=deadbeef", bus.out_result); end
    checks++; if (bus.out_we !== 1'b0) begin failures++; $error("FAIL rd0_we observed=%0h expected=0", bus.out_we); end
    drive(3'd7, 32'h0000_1000, 5'd9, 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    idle();
    checks++; if (bus.out_is_mem !== 1'b1) begin failures++; $error("FAIL mem_is_mem observed=%0h expected=1", bus.out_is_mem); end
    checks++; if (bus.out_we !== 1'b0) begin failures++; $error("FAIL mem_we observed=%0h expected=0", bus.out_we); end
    checks++; if (bus.out_result !== 32'h1000) begin failures++; $error("FAIL mem_result observed=%0h expected=1000", bus.out_result); end
    tick();

    // Overflowing SUB
    drive(3'd2, 32'h7FFF_FFFF, 5'd4, 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    idle();
`ifdef ALU_OVF_STATUS_EN
    checks++; if (bus.out_rd !== 5'd30) begin failures++; $error("FAIL ovf_rd observed=%0h expected=1e", bus.out_rd); end
    checks++; if (bus.out_result !== 32'd3) begin failures++; $error("FAIL ovf_result observed=%0h expected=3", bus.out_result); end
`else
    checks++; if (bus.out_rd !== 5'd4) begin failures++; $error("FAIL ovf_rd observed=%0h expected=4", bus.out_rd); end
    checks++; if (bus.out_result !== 32'h7FFF_FFFF) begin failures++; $error("FAIL ovf_result observed=%0h expected=7fffffff", bus.out_result); end
`endif
    checks++; if (bus.out_we !== 1'b1) begin failures++; $error("FAIL ovf_we observed=%0h expected=1", bus.out_we); end
    tick();

    // Flush with two held entries and a valid input in the same cycle
    bus.out_ready = 1'b0;
    drive(3'd1, 32'd11, 5'd1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(3'd1, 32'd12, 5'd2, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $error("FAIL pre_flush_full observed=%0h expected=0", bus.in_ready); end
    drive(3'd5, 32'd13, 5'd3, 1'b1, 1'b0, 1'b0, 32'h44);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $error("FAIL flush_out_valid observed=%0h expected=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $error("FAIL flush_in_ready observed=%0h expected=1", bus.in_ready); end
    checks++; if (bus.br_taken !== 1'b0) begin failures++; $error("FAIL flush_br_taken observed=%0h expected=0", bus.br_taken); end
    bus.out_ready = 1'b1;
    drive(3'd3, 32'd21, 5'd6, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    checks++; if (bus.out_result !== 32'd21) begin failures++; $error("FAIL post_flush_result observed=%0h expected=15", bus.out_result); end
    tick();

    // Asynchronous reset while an entry is held
    bus.out_ready = 1'b0;
    drive(3'd1, 32'd99, 5'd8, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(3'd5, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h88);
    tick();
    idle();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $error("FAIL pre_areset_valid observed=%0h expected=1", bus.out_valid); end
    checks++; if (bus.br_taken !== 1'b1) begin failures++; $error("FAIL pre_areset_br observed=%0h expected=1", bus.br_taken); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $error("FAIL areset_out_valid observed=%0h expected=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $error("FAIL areset_in_ready observed=%0h expected=1", bus.in_ready); end
    checks++; if (bus.br_taken !== 1'b0) begin failures++; $error("FAIL areset_br_taken observed=%0h expected=0", bus.br_taken); end
    checks++; if (bus.out_result !== 32'h0) begin failures++; $error("FAIL areset_out_result observed=%0h expected=0", bus.out_result); end
    tick();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
